// File: rtl/audio_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : audio_sequencer
// Brief    : Music sample playback controller. Accepts stop/play/pause/resume
//            commands over valid/ready, paces ROM reads at the sample rate,
//            walks a start..end address window (optionally looping) and
//            hands each fetched sample to the PWM stage with a strobe.
//            Also maintains a sample-position counter for note sync.
// Revision : 1.0 - initial release
// ============================================================================
module audio_sequencer #(
    parameter int CLK_HZ      = 100000000,
    parameter int SAMPLE_RATE = 1000,
    parameter int ADDR_W      = 18,
    parameter int ROM_LAT     = 1
) (
    input  logic              clk,
    input  logic              reset,
    // Command channel from game logic
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_start_addr,
    input  logic [ADDR_W-1:0] cmd_end_addr,
    input  logic              cmd_loop,
    // Sample ROM read port
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    // PWM stage and status
    output logic [7:0]        sample_out,
    output logic              sample_valid,
    output logic              playing,
    output logic              paused,
    output logic              done,
    output logic              err,
    output logic [31:0]       position
);

    // Clock cycles per sample period and the tick counter sized to hold it
    localparam int                    c_DIV       = CLK_HZ / SAMPLE_RATE;
    localparam int                    c_TICK_W    = (c_DIV > 1) ? $clog2(c_DIV) : 1;
    localparam logic [c_TICK_W-1:0]   c_TICK_LAST = c_TICK_W'(c_DIV - 1);
    localparam logic [c_TICK_W-1:0]   c_TICK_ONE  = c_TICK_W'(1);
    // ROM latency is 1..3, so a 2-bit wait counter always suffices
    localparam logic [1:0]            c_LAT_LAST  = 2'(ROM_LAT - 1);
    localparam logic [ADDR_W-1:0]     c_ADDR_ONE  = ADDR_W'(1);
    // PWM midpoint: the sample value that produces silence
    localparam logic [7:0]            c_SILENCE   = 8'h80;

    localparam logic [1:0] c_OP_STOP   = 2'b00;
    localparam logic [1:0] c_OP_PLAY   = 2'b01;
    localparam logic [1:0] c_OP_PAUSE  = 2'b10;
    localparam logic [1:0] c_OP_RESUME = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_PLAY   = 2'd1,
        S_FETCH  = 2'd2,
        S_PAUSED = 2'd3
    } state_t;

    // Registered state
    state_t              r_state;
    logic [c_TICK_W-1:0] r_tick;
    logic [1:0]          r_lat;
    logic [ADDR_W-1:0]   r_cur;
    logic [ADDR_W-1:0]   r_start;
    logic [ADDR_W-1:0]   r_end;
    logic                r_loop;
    logic                r_rom_en;
    logic [ADDR_W-1:0]   r_rom_addr;
    logic [7:0]          r_sample;
    logic                r_sample_valid;
    logic                r_done;
    logic                r_err;
    logic [31:0]         r_pos;

    // Next-state values
    state_t              w_state;
    logic [c_TICK_W-1:0] w_tick;
    logic [1:0]          w_lat;
    logic [ADDR_W-1:0]   w_cur;
    logic [ADDR_W-1:0]   w_start;
    logic [ADDR_W-1:0]   w_end;
    logic                w_loop;
    logic                w_rom_en;
    logic [ADDR_W-1:0]   w_rom_addr;
    logic [7:0]          w_sample;
    logic                w_sample_valid;
    logic                w_done;
    logic                w_err;
    logic [31:0]         w_pos;
    logic                w_advance;

    logic                w_accept;
    logic                w_play_ok;

    // A read in flight is never interrupted, so commands stall during FETCH
    assign cmd_ready = (r_state != S_FETCH);
    assign w_accept  = cmd_valid && cmd_ready;
    assign w_play_ok = (cmd_start_addr <= cmd_end_addr);

    assign rom_en       = r_rom_en;
    assign rom_addr     = r_rom_addr;
    assign sample_out   = r_sample;
    assign sample_valid = r_sample_valid;
    assign playing      = (r_state == S_PLAY) || (r_state == S_FETCH);
    assign paused       = (r_state == S_PAUSED);
    assign done         = r_done;
    assign err          = r_err;
    assign position     = r_pos;

    // Next-state, command decode, sample pacing and fetch completion
    always_comb begin
        w_state        = r_state;
        w_tick         = r_tick;
        w_lat          = r_lat;
        w_cur          = r_cur;
        w_start        = r_start;
        w_end          = r_end;
        w_loop         = r_loop;
        w_rom_en       = 1'b0;
        w_rom_addr     = r_rom_addr;
        w_sample       = r_sample;
        w_sample_valid = 1'b0;
        w_done         = 1'b0;
        w_err          = 1'b0;
        w_pos          = r_pos;
        w_advance      = 1'b0;

        case (r_state)
            S_FETCH: begin
                // The sample period keeps running while the read completes,
                // which keeps strobes exactly one period apart
                w_tick = r_tick + c_TICK_ONE;
                if (r_lat == c_LAT_LAST) begin
                    w_sample       = rom_data;
                    w_sample_valid = 1'b1;
                    w_pos          = r_pos + 32'd1;
                    if (r_cur == r_end) begin
                        if (r_loop) begin
                            w_cur   = r_start;
                            w_state = S_PLAY;
                        end else begin
                            w_done  = 1'b1;
                            w_state = S_IDLE;
                        end
                    end else begin
                        // cur < end here, so the increment cannot overflow
                        w_cur   = r_cur + c_ADDR_ONE;
                        w_state = S_PLAY;
                    end
                end else begin
                    w_lat = r_lat + 2'd1;
                end
            end

            default: begin
                // PLAY advances the tick every cycle unless a command
                // redirects it; rejected and no-op commands leave it running
                w_advance = (r_state == S_PLAY);
                if (w_accept) begin
                    case (cmd_op)
                        c_OP_STOP: begin
                            w_state   = S_IDLE;
                            w_sample  = c_SILENCE;
                            w_advance = 1'b0;
                        end
                        c_OP_PLAY: begin
                            if (w_play_ok) begin
                                w_start   = cmd_start_addr;
                                w_end     = cmd_end_addr;
                                w_loop    = cmd_loop;
                                w_cur     = cmd_start_addr;
                                w_pos     = 32'd0;
                                w_tick    = '0;
                                w_state   = S_PLAY;
                                w_advance = 1'b0;
                            end else begin
                                w_err = 1'b1;
                            end
                        end
                        c_OP_PAUSE: begin
                            if (r_state == S_PLAY) begin
                                w_state   = S_PAUSED;
                                w_advance = 1'b0;
                            end
                        end
                        default: begin
                            // The resume cycle counts as a playing cycle so
                            // the stream slips by exactly the paused cycles
                            if (r_state == S_PAUSED) begin
                                w_state   = S_PLAY;
                                w_advance = 1'b1;
                            end
                        end
                    endcase
                end

                if (w_advance) begin
                    if (r_tick == c_TICK_LAST) begin
                        w_tick     = '0;
                        w_rom_en   = 1'b1;
                        w_rom_addr = r_cur;
                        w_lat      = 2'd0;
                        w_state    = S_FETCH;
                    end else begin
                        w_tick = r_tick + c_TICK_ONE;
                    end
                end
            end
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state        <= S_IDLE;
            r_tick         <= '0;
            r_lat          <= 2'd0;
            r_cur          <= '0;
            r_start        <= '0;
            r_end          <= '0;
            r_loop         <= 1'b0;
            r_rom_en       <= 1'b0;
            r_rom_addr     <= '0;
            r_sample       <= c_SILENCE;
            r_sample_valid <= 1'b0;
            r_done         <= 1'b0;
            r_err          <= 1'b0;
            r_pos          <= 32'd0;
        end else begin
            r_state        <= w_state;
            r_tick         <= w_tick;
            r_lat          <= w_lat;
            r_cur          <= w_cur;
            r_start        <= w_start;
            r_end          <= w_end;
            r_loop         <= w_loop;
            r_rom_en       <= w_rom_en;
            r_rom_addr     <= w_rom_addr;
            r_sample       <= w_sample;
            r_sample_valid <= w_sample_valid;
            r_done         <= w_done;
            r_err          <= w_err;
            r_pos          <= w_pos;
        end
    end

endmodule
`default_nettype wire

// File: doc/audio_sequencer.md
# audio_sequencer

Playback controller for the music sample ROM. It accepts play, pause, resume and stop commands from game logic over a valid/ready handshake. It paces ROM reads at the sample rate, walks a start..end address window with optional looping, and presents each fetched 8-bit sample to the PWM stage with a one-cycle strobe. It also keeps a sample-position counter that the chart/judgement logic uses for note sync.

## Interface
- CLK_HZ, 100000000, system clock frequency
- SAMPLE_RATE, 1000, samples per second; DIV = CLK_HZ/SAMPLE_RATE (integer, must satisfy DIV > ROM_LAT+1)
- ADDR_W, 18, ROM address width
- ROM_LAT, 1, ROM read latency in cycles from rom_en to valid rom_data (1..3)
- clk  in  1  system clock
- reset  in  1  reset, synchronous, active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  command can be accepted this cycle
- cmd_op  in  2  00 stop, 01 play, 10 pause, 11 resume
- cmd_start_addr  in  ADDR_W  first sample address (play only)
- cmd_end_addr  in  ADDR_W  last sample address, inclusive (play only)
- cmd_loop  in  1  1 = wrap to start after end (play only)
- rom_en  out  1  ROM read strobe
- rom_addr  out  ADDR_W  ROM read address
- rom_data  in  8  ROM read data, valid ROM_LAT cycles after rom_en
- sample_out  out  8  current sample to PWM, held between strobes
- sample_valid  out  1  one-cycle pulse when sample_out updates
- playing  out  1  high in PLAY and FETCH
- paused  out  1  high in PAUSED
- done  out  1  one-cycle pulse at end of a non-looping track
- err  out  1  one-cycle pulse when a play command is rejected
- position  out  32  samples delivered since last accepted play; wraps mod 2^32

## Operation
- States: IDLE, PLAY, FETCH, PAUSED. Command accepted when cmd_valid && cmd_ready.
- cmd_ready = 0 in FETCH, 1 in all other states. Commands never interrupt an in-flight read.
- play with start <= end, from any state: latch start/end/loop; cur_addr = start; position = 0; tick counter = 0; go to PLAY.
- play with start > end: ignored; err pulses next cycle; state and all outputs unchanged.
- pause in PLAY: go to PAUSED; tick counter holds its value. resume in PAUSED: go to PLAY; the counter continues from the held value.
- stop in any state: go to IDLE; sample_out = 8'h80 (PWM midpoint/silence); position holds.
- pause in IDLE/PAUSED and resume in IDLE/PLAY: accepted no-ops, no err.
- Tick counter runs 0..DIV-1 in PLAY and FETCH. On the cycle counter == DIV-1 in PLAY:
  - rom_en = 1 and rom_addr = cur_addr (registered outputs, asserted that cycle).
  - Go to FETCH.
- FETCH waits ROM_LAT cycles, then captures rom_data into sample_out. In the same cycle:
  - sample_valid = 1 and position += 1.
  - If cur_addr == end and loop: cur_addr = start, back to PLAY.
  - If cur_addr == end and !loop: done = 1 and go to IDLE. sample_out keeps the last sample until the next stop or play.
  - Otherwise cur_addr += 1 and back to PLAY.
- rom_addr holds its last value when rom_en = 0. cur_addr == 2^ADDR_W-1 with end at the same value ends the track; it never overflows.

## Timing
- Reset values: rom_en 0, rom_addr 0, sample_out 8'h80, sample_valid 0, playing 0, paused 0, done 0, err 0, position 0, cmd_ready 1. State after reset is IDLE.
- Reset mid-FETCH aborts the read: no sample_valid, no done.
- Play accepted at edge E: the first rom_en occurs at cycle E+DIV, and the first sample_valid at E+DIV+ROM_LAT.
- Subsequent sample_valid pulses are exactly DIV cycles apart, including across a loop wrap.
- Pause/resume delays the sample stream by exactly the paused cycle count.
- playing, paused and cmd_ready update the cycle after the accepting edge.

## Test plan
Bench configuration: CLK_HZ=1000, SAMPLE_RATE=100 (DIV=10), ROM_LAT=1, ADDR_W=8, ROM model returns rom_data = addr ^ 8'h5A.
- Reset, then idle for 20 cycles -> sample_out 8'h80, rom_en never high, cmd_ready 1, position 0.
- play start=4 end=6 loop=0 at edge E:
  - rom_en at E+10/E+20/E+30 with addr 4/5/6.
  - sample_valid at E+11/E+21/E+31 with data 5E/5F/5C.
  - done with the third sample; position 3; playing low afterwards.
- play start=FE end=FF loop=1 -> addresses FE, FF, FE, FF; samples at 10-cycle spacing; done never pulses; position 4 after 4 samples.
- pause 3 cycles after the first sample, hold paused for 25 cycles, then resume -> next sample_valid at 10+25=35 cycles after the first; paused high only during the hold.
- Timing corner cases:
  - Drive cmd_valid stop held on the rom_en cycle -> cmd_ready 0 in FETCH; the stop is accepted after sample_valid; sample_out 8'h80 next cycle.
  - play start=9 end=3 -> err one pulse, state unchanged.
- Assert reset the cycle after rom_en -> no sample_valid; all outputs at reset values; a new play works normally.
